// File: rtl/sar_result_reader.sv
// SAR ADC result consumer: synchronizes the conversion-done strobe, captures the
// 6-bit code, optionally averages 2^AVG_LOG2 codes, and queues results for a stream sink.
module sar_result_reader #(
  parameter int DEPTH    = 4,
  parameter int AVG_LOG2 = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     rs_in,
  input  logic [5:0]               code_in,
  output logic [5:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     clear_ovf
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = AW + 1;
  localparam int ACC_W = 6 + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  // Handshake: a word transfers on every clk edge where out_valid and out_ready
  // are both high; out_data is stable while out_valid is high and out_ready is low.

  // Strobe synchronizer; flops reset high so a strobe held through reset is not an edge.
  logic s1, s2, s3;
  logic cap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= rs_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign cap = s2 & ~s3 & en;

  // Accumulator for averaging; with AVG_LOG2 = 0 cnt stays 0 so every capture pushes.
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic             push;
  logic [5:0]       push_word;

  assign sum       = acc + ACC_W'(code_in);
  assign last      = (cnt == CNT_LAST);
  assign push      = cap & last;
  assign push_word = sum[AVG_LOG2 +: 6];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (!en) begin
      acc <= '0;
      cnt <= '0;
    end else if (cap) begin
      if (last) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= sum;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Result FIFO; pointers carry one extra wrap bit so full and empty are distinct.
  logic [5:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          full;
  logic          pop;
  logic          wr_en;
  logic          drop;

  assign level     = wr_ptr - rd_ptr;
  assign full      = (level == PW'(DEPTH));
  assign out_valid = (wr_ptr != rd_ptr);
  assign out_data  = mem[rd_ptr[AW-1:0]];
  assign pop       = out_valid & out_ready;
  assign wr_en     = push & (~full | pop);
  assign drop      = push & full & ~pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr[AW-1:0]] <= push_word;
        wr_ptr              <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // A drop in the same cycle as clear_ovf leaves the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            overflow <= 1'b0;
    else if (drop)      overflow <= 1'b1;
    else if (clear_ovf) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_sar_result_reader.sv
// Bench for sar_result_reader: a pass-through and a 4-way averaging instance share
// stimulus and are checked every cycle against a queue-based reference model.
module tb_sar_result_reader;

  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       en = 1'b1;
  logic       rs_in = 1'b0;
  logic [5:0] code_in = '0;
  logic       out_ready = 1'b0;
  logic       clear_ovf = 1'b0;

  logic [5:0] dat [2];
  logic       val [2];
  logic [2:0] lvl [2];
  logic       ovf [2];

  sar_result_reader #(.DEPTH(DEPTH), .AVG_LOG2(0)) dut_a (
    .clk(clk), .rst(rst), .en(en), .rs_in(rs_in), .code_in(code_in),
    .out_data(dat[0]), .out_valid(val[0]), .out_ready(out_ready),
    .level(lvl[0]), .overflow(ovf[0]), .clear_ovf(clear_ovf)
  );

  sar_result_reader #(.DEPTH(DEPTH), .AVG_LOG2(2)) dut_b (
    .clk(clk), .rst(rst), .en(en), .rs_in(rs_in), .code_in(code_in),
    .out_data(dat[1]), .out_valid(val[1]), .out_ready(out_ready),
    .level(lvl[1]), .overflow(ovf[1]), .clear_ovf(clear_ovf)
  );

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // A capture at edge k comes from rs_in low at edge k-3 and high at edge k-2.
  bit h1, h2, h3;
  int navg [2] = '{1, 4};
  int mq [2][$];
  int msum [2];
  int mn [2];
  bit movf [2];
  int pop_log [2][$];
  int max_lvl = 0;

  task automatic model_reset();
    h1 = 1'b1; h2 = 1'b1; h3 = 1'b1;
    for (int d = 0; d < 2; d++) begin
      mq[d].delete();
      msum[d] = 0;
      mn[d]   = 0;
      movf[d] = 1'b0;
    end
  endtask

  task automatic model_step();
    bit cap;
    cap = h2 && !h3 && en;
    h3 = h2; h2 = h1; h1 = rs_in;
    for (int d = 0; d < 2; d++) begin
      bit pop, drop;
      if (val[d] && out_ready) pop_log[d].push_back(int'(dat[d]));
      pop = (mq[d].size() > 0) && out_ready;
      if (pop) void'(mq[d].pop_front());
      drop = 1'b0;
      if (!en) begin
        msum[d] = 0;
        mn[d]   = 0;
      end else if (cap) begin
        msum[d] += int'(code_in);
        mn[d]++;
        if (mn[d] == navg[d]) begin
          if (mq[d].size() < DEPTH) mq[d].push_back(msum[d] / navg[d]);
          else drop = 1'b1;
          msum[d] = 0;
          mn[d]   = 0;
        end
      end
      if (drop) movf[d] = 1'b1;
      else if (clear_ovf) movf[d] = 1'b0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // Scoreboard compare on the inactive edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int d = 0; d < 2; d++) begin
          chk($sformatf("valid[%0d]", d), 32'(val[d]), 32'(mq[d].size() > 0));
          chk($sformatf("level[%0d]", d), 32'(lvl[d]), 32'(mq[d].size()));
          chk($sformatf("overflow[%0d]", d), 32'(ovf[d]), 32'(movf[d]));
          if (mq[d].size() > 0) chk($sformatf("data[%0d]", d), 32'(dat[d]), 32'(mq[d][0]));
        end
        if (int'(lvl[0]) > max_lvl) max_lvl = int'(lvl[0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SAR strobe: high 3 periods, low 5; optionally pop on the capture edge only.
  task automatic strobe(input logic [5:0] c, input bit pop_at_cap);
    @(negedge clk);
    code_in = c;
    rs_in   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    if (pop_at_cap) out_ready = 1'b1;
    @(negedge clk);
    if (pop_at_cap) out_ready = 1'b0;
    rs_in = 1'b0;
    cycles(4);
  endtask

  task automatic check_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_valid[%0d]", tag, d), 32'(val[d]), 0);
      chk($sformatf("%s_level[%0d]", tag, d), 32'(lvl[d]), 0);
      chk($sformatf("%s_ovf[%0d]", tag, d), 32'(ovf[d]), 0);
      chk($sformatf("%s_data[%0d]", tag, d), 32'(dat[d]), 0);
    end
  endtask

  task automatic drain(input int n);
    @(negedge clk);
    out_ready = 1'b1;
    cycles(n);
    out_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  bit done = 1'b0;
  int sent [$];

  initial begin
    cycles(3);
    check_zero("reset");
    rst = 1'b0;
    cycles(2);

    // Pass-through single strobe with the sink always ready.
    out_ready = 1'b1;
    pop_log[0].delete();
    strobe(6'h2A, 1'b0);
    chk("pt_count", 32'(pop_log[0].size()), 1);
    chk("pt_word", 32'(pop_log[0][0]), 32'h2A);
    chk("pt_level", 32'(lvl[0]), 0);
    chk("pt_ovf", 32'(ovf[0]), 0);

    // Averaging: flush the partial group first.
    en = 1'b0;
    cycles(2);
    en = 1'b1;
    pop_log[1].delete();
    strobe(6'd10, 1'b0);
    strobe(6'd11, 1'b0);
    strobe(6'd12, 1'b0);
    chk("avg_none_yet", 32'(pop_log[1].size()), 0);
    strobe(6'd14, 1'b0);
    chk("avg_count", 32'(pop_log[1].size()), 1);
    chk("avg_word", 32'(pop_log[1][0]), 11);
    pop_log[1].delete();
    strobe(6'd1, 1'b0);
    strobe(6'd2, 1'b0);
    en = 1'b0;
    cycles(3);
    en = 1'b1;
    repeat (4) strobe(6'd63, 1'b0);
    chk("avg_en_count", 32'(pop_log[1].size()), 1);
    chk("avg_en_word", 32'(pop_log[1][0]), 63);

    // Fill and overflow.
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) strobe(6'(i), 1'b0);
    chk("fill_level", 32'(lvl[0]), 4);
    chk("fill_ovf", 32'(ovf[0]), 1);
    pop_log[0].delete();
    drain(4);
    chk("fill_popped", 32'(pop_log[0].size()), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("fill_order%0d", i), 32'(pop_log[0][i]), 32'(i + 1));
    @(negedge clk);
    clear_ovf = 1'b1;
    @(negedge clk);
    clear_ovf = 1'b0;
    chk("clear_ovf", 32'(ovf[0]), 0);

    // Full plus simultaneous pop/push.
    pop_log[0].delete();
    for (int i = 1; i <= 4; i++) strobe(6'(i), 1'b0);
    strobe(6'd9, 1'b1);
    chk("fullpop_level", 32'(lvl[0]), 4);
    chk("fullpop_ovf", 32'(ovf[0]), 0);
    drain(4);
    chk("fullpop_count", 32'(pop_log[0].size()), 5);
    chk("fullpop_w0", 32'(pop_log[0][1]), 2);
    chk("fullpop_w1", 32'(pop_log[0][2]), 3);
    chk("fullpop_w2", 32'(pop_log[0][3]), 4);
    chk("fullpop_w3", 32'(pop_log[0][4]), 9);
    drain(4);

    // Reset mid-activity with rs_in held high through release.
    for (int i = 0; i < 3; i++) strobe(6'(20 + i), 1'b0);
    @(negedge clk);
    rs_in = 1'b1;
    #2 rst = 1'b1;
    #1 check_zero("midrst");
    cycles(2);
    rst = 1'b0;
    cycles(6);
    chk("rshigh_nocap", 32'(lvl[0]), 0);
    rs_in = 1'b0;
    cycles(3);
    strobe(6'd7, 1'b0);
    chk("rs_recap", 32'(lvl[0]), 1);
    drain(3);

    // Pointer wrap with random sink back-pressure.
    pop_log[0].delete();
    max_lvl = 0;
    fork
      begin
        for (int i = 0; i < 3 * DEPTH; i++) begin
          logic [5:0] c;
          c = 6'($urandom_range(0, 63));
          sent.push_back(int'(c));
          strobe(c, 1'b0);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain(6);
    chk("wrap_count", 32'(pop_log[0].size()), 32'(sent.size()));
    for (int i = 0; i < sent.size() && i < pop_log[0].size(); i++)
      chk($sformatf("wrap_word%0d", i), 32'(pop_log[0][i]), 32'(sent[i]));
    chk("wrap_level_max", 32'(max_lvl <= DEPTH), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
